// File: rtl/mul4_pkg.sv
// Shared types, widths and the round-robin priority helper for the mul4 scheduler
// and any other arbiter that needs the same fairness rule.
package mul4_pkg;

  localparam int OPW    = 4;
  localparam int PW     = 8;
  localparam int MAXREQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Scans requesters from last+n down to last+1 (rotated modulo n); the final hit
  // is the one closest after last, so it wins. Returns -1 when nothing is requesting.
  function automatic int rr_pick(input logic [MAXREQ-1:0] req, input int last, input int n);
    int pick;
    int idx;
    pick = -1;
    idx  = 0;
    for (int k = MAXREQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[3'(idx)]) begin
          pick = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/array_multiplier_4bit.sv
// Combinational 4x4 unsigned array multiplier: AND-gated partial product rows
// accumulated row by row into a full 8-bit product.
module array_multiplier_4bit
  import mul4_pkg::*;
(
  input  logic [OPW-1:0] A,
  input  logic [OPW-1:0] B,
  output logic [PW-1:0]  P
);

  logic [PW-1:0] pp  [OPW];
  logic [PW-1:0] acc [OPW];

  for (genvar r = 0; r < OPW; r++) begin : g_row
    assign pp[r] = {{(PW-OPW){1'b0}}, A & {OPW{B[r]}}} << r;
    if (r == 0) begin : g_first
      assign acc[r] = pp[r];
    end else begin : g_next
      assign acc[r] = acc[r-1] + pp[r];
    end
  end

  assign P = acc[OPW-1];

endmodule

// File: rtl/mul4_rr_scheduler.sv
// Round-robin front end sharing one 4x4 array multiplier among NREQ requesters;
// one operation in flight, result returned with the owner's ID.
module mul4_rr_scheduler
  import mul4_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [OPW*NREQ-1:0]  req_a,
  input  logic [OPW*NREQ-1:0]  req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [PW-1:0]        res_p,
  output logic [IDW-1:0]       res_id,
  input  logic                 res_ready,
  output logic                 busy,
  output logic [15:0]          done_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; the producer holds valid and payload stable until then, and ready never
  // depends on anything downstream (req_ready has no path from res_ready).

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_a_q, op_a_d;
  logic [OPW-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [PW-1:0]    res_p_q, res_p_d;
  logic [IDW-1:0]   res_id_q, res_id_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      done_cnt_q, done_cnt_d;

  logic [OPW-1:0]   a_arr [NREQ];
  logic [OPW-1:0]   b_arr [NREQ];
  logic [OPW-1:0]   a_chain  [NREQ+1];
  logic [OPW-1:0]   b_chain  [NREQ+1];
  logic [IDW-1:0]   id_chain [NREQ+1];
  logic [NREQ-1:0]  grant;
  logic [OPW-1:0]   win_a;
  logic [OPW-1:0]   win_b;
  logic [IDW-1:0]   win_id;
  logic [PW-1:0]    mult_p;
  int               win_idx;

  assign win_idx = rr_pick(MAXREQ'(req_valid), int'(last_grant_q), NREQ);

  assign a_chain[0]  = '0;
  assign b_chain[0]  = '0;
  assign id_chain[0] = '0;

  // Grant is one-hot, so OR-ing the masked lanes selects the winner's operands.
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign a_arr[g]      = req_a[OPW*g +: OPW];
    assign b_arr[g]      = req_b[OPW*g +: OPW];
    assign grant[g]      = (win_idx == g);
    assign a_chain[g+1]  = a_chain[g] | (a_arr[g] & {OPW{grant[g]}});
    assign b_chain[g+1]  = b_chain[g] | (b_arr[g] & {OPW{grant[g]}});
    assign id_chain[g+1] = id_chain[g] | (grant[g] ? IDW'(g) : '0);
  end

  assign win_a  = a_chain[NREQ];
  assign win_b  = b_chain[NREQ];
  assign win_id = id_chain[NREQ];

  array_multiplier_4bit u_mult (
    .A (op_a_q),
    .B (op_b_q),
    .P (mult_p)
  );

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    res_p_d      = res_p_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          state_d      = CALC;
          op_a_d       = win_a;
          op_b_d       = win_b;
          op_id_d      = win_id;
          last_grant_d = win_id;
        end
      end
      CALC: begin
        state_d     = DONE;
        res_p_d     = mult_p;
        res_id_d    = op_id_q;
        res_valid_d = 1'b1;
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      res_p_q      <= '0;
      res_id_q     <= '0;
      res_valid_q  <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      last_grant_q <= last_grant_d;
      res_p_q      <= res_p_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign res_valid = res_valid_q;
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);
  assign done_cnt  = done_cnt_q;

endmodule
